// File: rtl/block_requester.sv
// Initiator for the block enable/ack handshake: one request at a time, setup cycle,
// four-phase enable/ack with a per-phase timeout, one registered response per request.
module block_requester #(
   parameter int NUM_BLOCKS = 4,
   parameter int ADDR_W     = 2,
   parameter int DATA_W     = 16,
   parameter int TIMEOUT    = 15
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_write,
   input  logic                         req_clear,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [DATA_W-1:0]            req_wdata,
   output logic                         resp_valid,
   output logic [DATA_W-1:0]            resp_rdata,
   output logic                         resp_err,
   output logic [NUM_BLOCKS-1:0]        blk_enable,
   output logic                         blk_write,
   output logic                         blk_rst,
   output logic [DATA_W-1:0]            blk_data_in,
   input  logic [NUM_BLOCKS*DATA_W-1:0] blk_data_out,
   input  logic [NUM_BLOCKS-1:0]        blk_ack
);

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACK_WAIT,
      RELEASE,
      RESP
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_q, addr_nxt;
   logic [DATA_W-1:0]   wdata_q, wdata_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_inc;
   logic                timed_out;
   logic [NUM_BLOCKS-1:0] enable_nxt;
   logic                write_nxt, clear_nxt;
   logic [DATA_W-1:0]   data_in_nxt;
   logic                resp_valid_nxt, resp_err_nxt;
   logic [DATA_W-1:0]   resp_rdata_nxt;
   logic                addr_legal;
   logic                sel_ack;
   logic [DATA_W-1:0]   sel_data;
   logic [NUM_BLOCKS-1:0] sel_onehot;

   assign req_ready  = (state == IDLE);
   assign addr_legal = (int'(req_addr) < NUM_BLOCKS);

   // Only the latched target block's ack and data are ever looked at.
   always_comb begin
      sel_ack    = 1'b0;
      sel_data   = '0;
      sel_onehot = '0;
      for (int i = 0; i < NUM_BLOCKS; i++) begin
         if (addr_q == ADDR_W'(i)) begin
            sel_ack       = blk_ack[i];
            sel_data      = blk_data_out[i*DATA_W +: DATA_W];
            sel_onehot[i] = 1'b1;
         end
      end
   end

   // Saturating phase counter: it can never wrap back below TIMEOUT.
   assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
   assign timed_out = (cnt_inc == CNT_MAX);

   // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt      = state;
      addr_nxt       = addr_q;
      wdata_nxt      = wdata_q;
      cnt_nxt        = cnt;
      enable_nxt     = '0;
      write_nxt      = blk_write;
      clear_nxt      = blk_rst;
      data_in_nxt    = blk_data_in;
      resp_valid_nxt = 1'b0;
      resp_rdata_nxt = resp_rdata;
      resp_err_nxt   = resp_err;

      case (state)
         IDLE: begin
            if (req_valid) begin
               addr_nxt       = req_addr;
               wdata_nxt      = req_wdata;
               resp_rdata_nxt = '0;
               if (!addr_legal) begin
                  resp_err_nxt   = 1'b1;
                  resp_valid_nxt = 1'b1;
                  state_nxt      = RESP;
               end else begin
                  resp_err_nxt = 1'b0;
                  write_nxt    = req_write & ~req_clear;
                  clear_nxt    = req_clear;
                  data_in_nxt  = req_wdata;
                  state_nxt    = SETUP;
               end
            end
         end
         SETUP: begin
            cnt_nxt    = '0;
            enable_nxt = sel_onehot;
            state_nxt  = ACK_WAIT;
         end
         ACK_WAIT: begin
            cnt_nxt = cnt_inc;
            if (sel_ack) begin
               resp_rdata_nxt = sel_data;
               cnt_nxt        = '0;
               state_nxt      = RELEASE;
            end else if (timed_out) begin
               resp_err_nxt   = 1'b1;
               resp_rdata_nxt = '0;
               cnt_nxt        = '0;
               state_nxt      = RELEASE;
            end else begin
               enable_nxt = sel_onehot;
            end
         end
         RELEASE: begin
            cnt_nxt = cnt_inc;
            if (!sel_ack || timed_out) begin
               if (sel_ack) resp_err_nxt = 1'b1;
               resp_valid_nxt = 1'b1;
               write_nxt      = 1'b0;
               clear_nxt      = 1'b0;
               data_in_nxt    = '0;
               cnt_nxt        = '0;
               state_nxt      = RESP;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // NOTE: all state below updates with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt         <= '0;
         blk_enable  <= '0;
         blk_write   <= 1'b0;
         blk_rst     <= 1'b0;
         blk_data_in <= '0;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
      end else begin
         state       <= state_nxt;
         addr_q      <= addr_nxt;
         wdata_q     <= wdata_nxt;
         cnt         <= cnt_nxt;
         blk_enable  <= enable_nxt;
         blk_write   <= write_nxt;
         blk_rst     <= clear_nxt;
         blk_data_in <= data_in_nxt;
         resp_valid  <= resp_valid_nxt;
         resp_rdata  <= resp_rdata_nxt;
         resp_err    <= resp_err_nxt;
      end
   end

endmodule

// File: tb/tb_block_requester.sv
// Randomised bench for block_requester: behavioural block array plus a reference model that
// predicts response data, error, latency and enable duration from the handshake rules.
module tb_block_requester;

   localparam int NB      = 3;
   localparam int AW      = 2;
   localparam int DW      = 16;
   localparam int TIMEOUT = 15;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid, req_ready, req_write, req_clear;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   req_wdata;
   logic            resp_valid, resp_err;
   logic [DW-1:0]   resp_rdata;
   logic [NB-1:0]   blk_enable;
   logic            blk_write, blk_rst;
   logic [DW-1:0]   blk_data_in;
   logic [NB*DW-1:0] blk_data_out;
   logic [NB-1:0]   blk_ack;

   int n_checks = 0;
   int n_fail   = 0;

   // Block array environment: programmable ack delay, dead (never acks) or stuck (ack always high).
   int           dly   [NB];
   bit           dead  [NB];
   bit           stuck [NB];
   logic [3:0]   en_hist [NB];
   logic [DW-1:0] bmem  [NB];
   // Reference model's view of block contents.
   logic [DW-1:0] ref_mem [NB];

   always #5 clk = ~clk;

   block_requester #(
      .NUM_BLOCKS(NB), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_clear(req_clear), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .blk_enable(blk_enable), .blk_write(blk_write), .blk_rst(blk_rst),
      .blk_data_in(blk_data_in), .blk_data_out(blk_data_out), .blk_ack(blk_ack)
   );

   always_comb begin
      blk_ack      = '0;
      blk_data_out = '0;
      for (int i = 0; i < NB; i++) begin
         if (dead[i])         blk_ack[i] = 1'b0;
         else if (stuck[i])   blk_ack[i] = 1'b1;
         else if (dly[i] == 0) blk_ack[i] = blk_enable[i];
         else                 blk_ack[i] = en_hist[i][dly[i]-1];
         if (blk_enable[i] && !dead[i] && blk_rst)        blk_data_out[i*DW +: DW] = '0;
         else if (blk_enable[i] && !dead[i] && blk_write) blk_data_out[i*DW +: DW] = blk_data_in;
         else                                             blk_data_out[i*DW +: DW] = bmem[i];
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (rst) en_hist[i] <= '0;
         else     en_hist[i] <= {en_hist[i][2:0], blk_enable[i]};
         if (blk_enable[i] && !dead[i]) begin
            if (blk_rst)        bmem[i] <= '0;
            else if (blk_write) bmem[i] <= blk_data_in;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Issue one request from a negedge in IDLE and check the whole transaction against the model.
   task automatic run_req(input bit w, input bit c, input logic [AW-1:0] a, input logic [DW-1:0] wd);
      int            exp_lat, exp_en, lat, en_cnt;
      logic          exp_err;
      logic [DW-1:0] exp_rd, newv;
      logic [NB-1:0] mask;
      bit            legal, got, other_en, shared_bad;

      legal = (int'(a) < NB);
      for (int i = 0; i < NB; i++) mask[i] = legal && (int'(a) == i);
      if (!legal) begin
         exp_lat = 1; exp_en = 0; exp_err = 1'b1; exp_rd = '0;
      end else begin
         newv = c ? '0 : (w ? wd : ref_mem[a]);
         if (dead[a]) begin
            exp_lat = TIMEOUT + 3; exp_en = TIMEOUT; exp_err = 1'b1; exp_rd = '0;
         end else if (stuck[a]) begin
            exp_lat = TIMEOUT + 3; exp_en = 1; exp_err = 1'b1; exp_rd = newv;
            ref_mem[a] = newv;
         end else begin
            exp_lat = 2 * dly[a] + 4; exp_en = dly[a] + 1; exp_err = 1'b0; exp_rd = newv;
            ref_mem[a] = newv;
         end
      end

      check("ready_before_req", req_ready, 1'b1);
      req_valid = 1'b1; req_write = w; req_clear = c; req_addr = a; req_wdata = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'($urandom); req_clear = 1'($urandom); req_wdata = 16'($urandom);

      lat = 0; en_cnt = 0; got = 0; other_en = 0; shared_bad = 0;
      while (lat < 200 && !got) begin
         lat++;
         if ((blk_enable & ~mask) != '0) other_en = 1;
         if ((blk_enable & mask) != '0) begin
            en_cnt++;
            if (blk_write !== (w & ~c) || blk_rst !== c || blk_data_in !== wd) shared_bad = 1;
         end
         if (resp_valid === 1'b1) got = 1;
         else @(negedge clk);
      end
      check("resp_seen", got, 1'b1);
      check("resp_latency", lat, exp_lat);
      check("enable_cycles", en_cnt, exp_en);
      check("foreign_enable", other_en, 1'b0);
      check("shared_lines", shared_bad, 1'b0);
      check("resp_err", resp_err, exp_err);
      check("resp_rdata", resp_rdata, exp_rd);
      check("shared_idle_at_resp", {blk_write, blk_rst, blk_data_in}, '0);
      @(negedge clk);
      check("resp_one_cycle", resp_valid, 1'b0);
      check("ready_after_resp", req_ready, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NB; i++) begin
         dly[i] = 0; dead[i] = 0; stuck[i] = 0; bmem[i] = '0; ref_mem[i] = '0;
      end
      rst = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_clear = 1'b0; req_addr = 2'd1; req_wdata = 16'hA5A5;

      // Reset held with a request pending: nothing may start.
      repeat (3) begin
         @(negedge clk);
         check("reset_outputs",
               {blk_enable, blk_write, blk_rst, blk_data_in, resp_valid, resp_rdata, resp_err}, '0);
      end
      rst = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      check("ready_after_reset", req_ready, 1'b1);
      check("idle_after_reset", {blk_enable, resp_valid}, '0);

      // Write then read-back on block 2, immediate and one-cycle-delayed acks.
      dly[2] = 0;
      run_req(1'b1, 1'b0, 2'd2, 16'hBEEF);
      dly[2] = 1;
      run_req(1'b0, 1'b0, 2'd2, 16'h0000);

      // Clear wins over write.
      dly[1] = 2;
      run_req(1'b1, 1'b0, 2'd1, 16'h1234);
      run_req(1'b1, 1'b1, 2'd1, 16'h5678);
      check("block1_cleared", bmem[1], 16'h0000);
      run_req(1'b0, 1'b0, 2'd1, 16'h0000);

      // Dead block: enable held for exactly TIMEOUT cycles, error response.
      dead[0] = 1;
      run_req(1'b1, 1'b0, 2'd0, 16'hDEAD);
      dead[0] = 0;
      dly[0]  = 3;
      run_req(1'b0, 1'b0, 2'd0, 16'h0000);

      // Ack never released: release phase times out with data still returned.
      stuck[2] = 1;
      run_req(1'b0, 1'b0, 2'd2, 16'h0000);
      stuck[2] = 0;
      @(negedge clk);

      // Illegal address.
      run_req(1'b1, 1'b0, 2'd3, 16'hFFFF);

      // Reset during ACK_WAIT aborts with no response.
      dly[1] = 3;
      req_valid = 1'b1; req_write = 1'b0; req_clear = 1'b0; req_addr = 2'd1; req_wdata = 16'h0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      begin
         int waited;
         waited = 0;
         while (blk_enable == '0 && waited < 10) begin
            @(negedge clk);
            waited++;
         end
         check("abort_enable_seen", blk_enable, 3'b010);
      end
      rst = 1'b1;
      @(negedge clk);
      check("abort_enable_drop", blk_enable, '0);
      check("abort_no_resp", resp_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("abort_quiet", {resp_valid, blk_enable}, '0);
      end
      run_req(1'b0, 1'b0, 2'd1, 16'h0000);

      // Randomised traffic.
      for (int n = 0; n < 40; n++) begin
         logic [AW-1:0] a;
         a = AW'($urandom_range(0, 3));
         for (int i = 0; i < NB; i++) dly[i] = $urandom_range(0, 3);
         if (int'(a) < NB) dead[a] = ($urandom_range(0, 9) == 0);
         run_req(1'($urandom), ($urandom_range(0, 3) == 0), a, 16'($urandom));
         for (int i = 0; i < NB; i++) dead[i] = 0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int i = 0; i < NB; i++) check("final_block_contents", bmem[i], ref_mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
